uart_tx_arbiter: RTL and testbench



---
 rtl/uart_arb_pkg.sv | 12 +
 rtl/arb_idle_timer.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-requester UART TX byte-stream arbiter.
package uart_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int NUM_REQ = 2;

  localparam logic [NUM_REQ-1:0] GNT_NONE = 2'b00;
  localparam logic [NUM_REQ-1:0] GNT_REQ0 = 2'b01;
  localparam logic [NUM_REQ-1:0] GNT_REQ1 = 2'b10;

endpackage

// File: rtl/arb_idle_timer.sv
// Owner-idle counter: clears on clr, counts while en, strobes expire on the
// cycle it sits at TIMEOUT_CYC-1 with en still high. Saturates instead of wrapping.
module arb_idle_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] cnt;

  assign expire = en && (cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (en && (cnt != TW'(TIMEOUT_CYC)))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX byte stream between two
// requesters, with idle-owner revocation. Define UART_ARB_STATS_EN for packet/timeout counters.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 100000
`ifdef UART_ARB_STATS_EN
  , parameter int CNT_W     = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              timeout_pulse
`ifdef UART_ARB_STATS_EN
  , output logic [CNT_W-1:0] pkt_cnt0
  , output logic [CNT_W-1:0] pkt_cnt1
  , output logic [CNT_W-1:0] to_cnt
`endif
);

  arb_state_t state, state_nxt;
  logic       owner, owner_nxt;
  logic       rr_ptr, rr_ptr_nxt;

  logic [NUM_REQ-1:0]             vld, lst, rdy;
  logic [NUM_REQ-1:0][DATA_W-1:0] dat;
  logic own_valid, hs, done, expire, timer_clr, timer_en;

  assign vld = {req1_valid, req0_valid};
  assign lst = {req1_last,  req0_last};
  assign dat = {req1_data,  req0_data};
  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];

  assign own_valid = vld[owner];
  assign busy      = (state == ARB_GRANT);
  assign grant     = busy ? (owner ? GNT_REQ1 : GNT_REQ0) : GNT_NONE;

  // Only owner silence counts; a downstream stall with valid high holds the timer.
  assign timer_en  = busy && !own_valid;
  assign timer_clr = !busy || hs || expire;

  arb_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (expire)
  );

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    tx_valid      = 1'b0;
    tx_data       = '0;
    rdy           = '0;
    hs            = 1'b0;
    done          = 1'b0;
    timeout_pulse = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (|vld) begin
          state_nxt = ARB_GRANT;
          owner_nxt = (&vld) ? rr_ptr : vld[1];
        end
      end
      ARB_GRANT: begin
        tx_valid      = own_valid;
        tx_data       = dat[owner];
        rdy[owner]    = tx_ready;
        hs            = own_valid && tx_ready;
        done          = hs && lst[owner];
        timeout_pulse = expire;
        if (done || expire) begin
          state_nxt  = ARB_IDLE;
          rr_ptr_nxt = ~owner;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ARB_IDLE;
      owner  <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

`ifdef UART_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
      to_cnt   <= '0;
    end else begin
      if (done && !owner) pkt_cnt0 <= pkt_cnt0 + 1'b1;
      if (done &&  owner) pkt_cnt1 <= pkt_cnt1 + 1'b1;
      if (timeout_pulse)  to_cnt   <= to_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with TIMEOUT_CYC=8.
module tb_uart_tx_arbiter;

  localparam int DATA_W = 8;
  localparam int TO     = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req0_last, req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid, req1_last, req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic              tx_valid, tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [1:0]        grant;
  logic              busy, timeout_pulse;
`ifdef UART_ARB_STATS_EN
  logic [1:0] pkt_cnt0, pkt_cnt1, to_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .DATA_W(DATA_W), .TIMEOUT_CYC(TO)
`ifdef UART_ARB_STATS_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse)
`ifdef UART_ARB_STATS_EN
    , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .to_cnt(to_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the edge; checks run 3 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 0; req0_last = 0; req0_data = '0;
    req1_valid = 0; req1_last = 0; req1_data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_ready = 1'b1;
    do_reset();
    req0_last = 1'b1;  // last without valid is ignored
    settle();
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 8'h00);
    chk("rst_rdy", {req1_ready, req0_ready}, 2'b00);
    chk("rst_to", timeout_pulse, 0);
    tick(); settle();
    chk("last_only_idle", grant, 2'b00);

    // req0: 3-byte packet 41 42 43
    req0_valid = 1; req0_data = 8'h41; req0_last = 0; settle();
    chk("p0_pre_grant", grant, 2'b00);
    chk("p0_pre_rdy", req0_ready, 0);
    tick(); settle();
    chk("p0_grant", grant, 2'b01);
    chk("p0_b0", tx_data, 8'h41);
    chk("p0_txv", tx_valid, 1);
    chk("p0_rdy", req0_ready, 1);
    chk("p0_r1rdy", req1_ready, 0);
    tick(); req0_data = 8'h42; settle();
    chk("p0_b1", tx_data, 8'h42);
    tick(); req0_data = 8'h43; req0_last = 1; settle();
    chk("p0_b2", tx_data, 8'h43);
    chk("p0_r1rdy2", req1_ready, 0);
    tick(); req0_valid = 0; req0_last = 0; settle();
    chk("p0_idle", grant, 2'b00);
    chk("p0_idle_txv", tx_valid, 0);

    // contention after reset: req0 first, one bubble, then req1
    do_reset();
    req0_valid = 1; req0_data = 8'h10; req0_last = 1;
    req1_valid = 1; req1_data = 8'h20; req1_last = 1;
    tick(); settle();
    chk("rr_first", grant, 2'b01);
    chk("rr_first_d", tx_data, 8'h10);
    chk("rr_r1rdy", req1_ready, 0);
    tick(); req0_valid = 0; req0_last = 0; settle();
    chk("rr_bubble", grant, 2'b00);
    chk("rr_bubble_txv", tx_valid, 0);
    tick(); settle();
    chk("rr_second", grant, 2'b10);
    chk("rr_second_d", tx_data, 8'h20);
    chk("rr_second_rdy", req1_ready, 1);
    tick(); req1_valid = 0; req1_last = 0; settle();
    chk("rr_done", grant, 2'b00);

    // req1 stalls mid-packet: revoked after TO idle cycles
    req1_valid = 1; req1_data = 8'h55; req1_last = 0;
    tick(); settle();
    chk("to_grant", grant, 2'b10);
    tick(); req1_valid = 0; req0_valid = 1; req0_data = 8'h66; req0_last = 1; settle();
    chk("to_r0rdy", req0_ready, 0);
    for (int k = 1; k < TO; k++) begin
      chk("to_early", timeout_pulse, 0);
      chk("to_hold", grant, 2'b10);
      tick(); settle();
    end
    chk("to_pulse", timeout_pulse, 1);
    chk("to_pulse_grant", grant, 2'b10);
    tick(); settle();
    chk("to_revoked", grant, 2'b00);
    chk("to_pulse_off", timeout_pulse, 0);
    tick(); settle();
    chk("to_next", grant, 2'b01);
    chk("to_next_d", tx_data, 8'h66);
    tick(); req0_valid = 0; req0_last = 0; settle();
    chk("to_next_done", grant, 2'b00);

    // downstream stall with owner valid: no timeout
    tx_ready = 0; req0_valid = 1; req0_data = 8'h77; req0_last = 1;
    tick(); settle();
    for (int k = 0; k < 20; k++) begin
      chk("st_grant", grant, 2'b01);
      chk("st_txv", tx_valid, 1);
      chk("st_to", timeout_pulse, 0);
      chk("st_rdy", req0_ready, 0);
      tick(); settle();
    end
    tx_ready = 1; settle();
    chk("st_rdy_up", req0_ready, 1);
    chk("st_data", tx_data, 8'h77);
    tick(); req0_valid = 0; req0_last = 0; settle();
    chk("st_done", grant, 2'b00);
    chk("st_no_to", timeout_pulse, 0);

    // reset on byte 2 of 4 (rr_ptr is 1 here)
    req0_valid = 1; req0_data = 8'h81; req0_last = 0;
    tick(); settle();
    chk("mr_grant", grant, 2'b01);
    tick(); req0_data = 8'h82; settle();
    chk("mr_b1", tx_data, 8'h82);
    reset = 1;
    tick(); reset = 0; req0_data = 8'h83; req1_valid = 1; req1_data = 8'h99; req1_last = 1; settle();
    chk("mr_grant0", grant, 2'b00);
    chk("mr_txv0", tx_valid, 0);
    chk("mr_to", timeout_pulse, 0);
    tick(); settle();
    chk("mr_rrptr0", grant, 2'b01);
    chk("mr_d", tx_data, 8'h83);

`ifdef UART_ARB_STATS_EN
    begin
      logic [1:0] exp_cnt [5];
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      chk("st_cnt_rst", pkt_cnt0, 0);
      req0_valid = 1; req0_data = 8'h30; req0_last = 1;
      for (int i = 0; i < 5; i++) begin
        tick(); tick(); settle();
        chk("pkt_cnt0", pkt_cnt0, exp_cnt[i]);
        chk("to_cnt", to_cnt, 0);
        chk("pkt_cnt1", pkt_cnt1, 0);
      end
      req0_valid = 0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
